// File: rtl/bk_pkg.sv
// Shared types and helpers for the pipelined Brent-Kung adder/subtractor.
//   op_e          : operation select (OP_ADD / OP_SUB)
//   pg_t          : one bit position's propagate/generate pair; vectors are
//                   built as packed arrays pg_t [WIDTH-1:0]
//   clog2_levels  : prefix-tree depth for a given width, usable in localparams
package bk_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int clog2_levels(input int width);
    int n;
    n = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < width) n = k + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// Brent-Kung black cell: merges a high group (hi) with the adjacent lower
// group (lo) into one combined propagate/generate pair.
//   p_hi_i, g_hi_i : P/G of the more significant group
//   p_lo_i, g_lo_i : P/G of the less significant group
//   p_o, g_o       : combined group P/G
module bk_prefix_cell (
  input  logic p_hi_i,
  input  logic g_hi_i,
  input  logic p_lo_i,
  input  logic g_lo_i,
  output logic p_o,
  output logic g_o
);

  assign p_o = p_hi_i & p_lo_i;
  assign g_o = g_hi_i | (p_hi_i & g_lo_i);

endmodule

// File: rtl/bk_adder_pipe.sv
// Three-stage pipelined Brent-Kung adder/subtractor with valid/ready on both
// sides. S1 forms per-bit P/G (carry-in folded into bit 0), S2 runs the
// up-sweep, S3 runs the down-sweep and forms sum and flags.
//
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   valid_i / ready_o   : input handshake
//   a_i, b_i, carry_i   : operands and carry-in (carry-in ignored in SUB)
//   op_i                : OP_ADD / OP_SUB
//   valid_o / ready_i   : output handshake
//   sum_o, carry_o      : result and carry-out (SUB: 1 = no borrow)
//   overflow_o, zero_o  : signed overflow, sum == 0
//
// Build option: define BK_ADDER_PIPE_FLAGS_EN to compute overflow_o/zero_o;
// without it both are tied low and the sign-bit pipeline is absent.
module bk_adder_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  op_e              op_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int LVL = clog2_levels(WIDTH);

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("bk_adder_pipe: WIDTH must be a power of two in 8..64");
  end

  // ---------------------------------------------------------------- control
  logic s1_v_q, s2_v_q, s3_v_q;
  logic s1_v_d, s2_v_d, s3_v_d;
  logic s1_free, s2_free, s3_free;
  logic s1_ld, s2_ld, s3_ld;

  // A stage can take new data if it is empty or its content moves on now;
  // this chains combinationally from ready_i back to ready_o.
  assign s3_free = !s3_v_q || ready_i;
  assign s2_free = !s2_v_q || s3_free;
  assign s1_free = !s1_v_q || s2_free;
  assign ready_o = s1_free;

  assign s1_ld = s1_free && valid_i;
  assign s2_ld = s2_free && s1_v_q;
  assign s3_ld = s3_free && s2_v_q;

  always_comb begin
    s1_v_d = s1_free ? valid_i : s1_v_q;
    s2_v_d = s2_free ? s1_v_q  : s2_v_q;
    s3_v_d = s3_free ? s2_v_q  : s3_v_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s3_v_q <= s3_v_d;
    end
  end

  assign valid_o = s3_v_q;

  // ---------------------------------------------------------------- S1
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  pg_t  [WIDTH-1:0] s1_pg_d, s1_pg_q;
  logic             s1_cin_q;

  always_comb begin
    b_eff   = (op_i == OP_SUB) ? ~b_i : b_i;
    cin_eff = (op_i == OP_SUB) ? 1'b1 : carry_i;
    for (int i = 0; i < WIDTH; i++) begin
      s1_pg_d[i].p = a_i[i] ^ b_eff[i];
      s1_pg_d[i].g = a_i[i] & b_eff[i];
    end
    // Folding cin into G0 makes every group G a true carry-out.
    s1_pg_d[0].g = s1_pg_d[0].g | (s1_pg_d[0].p & cin_eff);
  end

  always_ff @(posedge clk_i) begin
    if (s1_ld) begin
      s1_pg_q  <= s1_pg_d;
      s1_cin_q <= cin_eff;
    end
  end

  // ---------------------------------------------------------------- S2
  // Up-sweep: at level l, node i with (i+1) a multiple of 2^(l+1) absorbs
  // the group ending 2^l below it.
  for (genvar l = 0; l < LVL; l++) begin : g_up
    pg_t [WIDTH-1:0] prv;
    pg_t [WIDTH-1:0] nxt;
    if (l == 0) begin : g_src
      assign prv = s1_pg_q;
    end else begin : g_src
      assign prv = g_up[l-1].nxt;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i + 1) % (2 << l)) == 0) begin : g_cell
        bk_prefix_cell u_cell (
          .p_hi_i (prv[i].p),
          .g_hi_i (prv[i].g),
          .p_lo_i (prv[i-(1<<l)].p),
          .g_lo_i (prv[i-(1<<l)].g),
          .p_o    (nxt[i].p),
          .g_o    (nxt[i].g)
        );
      end else begin : g_pass
        assign nxt[i] = prv[i];
      end
    end
  end

  pg_t  [WIDTH-1:0] s2_grp_q;
  logic [WIDTH-1:0] s2_p_q;
  logic             s2_cin_q;
  logic [WIDTH-1:0] s1_raw_p;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) s1_raw_p[i] = s1_pg_q[i].p;
  end

  always_ff @(posedge clk_i) begin
    if (s2_ld) begin
      s2_grp_q <= g_up[LVL-1].nxt;
      s2_p_q   <= s1_raw_p;
      s2_cin_q <= s1_cin_q;
    end
  end

  // ---------------------------------------------------------------- S3
  // Down-sweep: at level l (from LVL-2 down to 0), nodes at 3*2^l-1 stepping
  // by 2^(l+1) pick up the full prefix sitting 2^l below them.
  for (genvar d = 0; d < LVL - 1; d++) begin : g_dn
    localparam int L = LVL - 2 - d;
    pg_t [WIDTH-1:0] prv;
    pg_t [WIDTH-1:0] nxt;
    if (d == 0) begin : g_src
      assign prv = s2_grp_q;
    end else begin : g_src
      assign prv = g_dn[d-1].nxt;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i + 1) % (2 << L)) == (1 << L) && (i + 1) > (2 << L)) begin : g_cell
        bk_prefix_cell u_cell (
          .p_hi_i (prv[i].p),
          .g_hi_i (prv[i].g),
          .p_lo_i (prv[i-(1<<L)].p),
          .g_lo_i (prv[i-(1<<L)].g),
          .p_o    (nxt[i].p),
          .g_o    (nxt[i].g)
        );
      end else begin : g_pass
        assign nxt[i] = prv[i];
      end
    end
  end

  logic [WIDTH-1:0] carry_vec;
  logic [WIDTH-1:0] dn_p;
  logic             unused_dn_p;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      carry_vec[i] = g_dn[LVL-2].nxt[i].g;
      dn_p[i]      = g_dn[LVL-2].nxt[i].p;
    end
    sum_d[0] = s2_p_q[0] ^ s2_cin_q;
    for (int i = 1; i < WIDTH; i++) sum_d[i] = s2_p_q[i] ^ carry_vec[i-1];
    carry_d = carry_vec[WIDTH-1];
  end

  // Group propagates are not needed once all carries are known.
  assign unused_dn_p = ^dn_p;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (s3_ld) begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = carry_q;

`ifdef BK_ADDER_PIPE_FLAGS_EN
  logic s1_as_q, s1_bs_q, s2_as_q, s2_bs_q;
  logic ovf_d, zero_d, ovf_q, zero_q;

  always_ff @(posedge clk_i) begin
    if (s1_ld) begin
      s1_as_q <= a_i[WIDTH-1];
      s1_bs_q <= b_eff[WIDTH-1];
    end
    if (s2_ld) begin
      s2_as_q <= s1_as_q;
      s2_bs_q <= s1_bs_q;
    end
  end

  always_comb begin
    ovf_d  = (s2_as_q == s2_bs_q) && (sum_d[WIDTH-1] != s2_as_q);
    zero_d = (sum_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (s3_ld) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign overflow_o = ovf_q;
  assign zero_o     = zero_q;
`else
  assign overflow_o = 1'b0;
  assign zero_o     = 1'b0;
`endif

endmodule
